mul_add_accum_result_mem: RTL and testbench

//  Banked result store for the multiply-add array: one row = NO_OF_UNITS lanes of ELEMENT_WIDTH.

---
 rtl/mul_add_accum_result_mem_if.sv | 36 +++
 rtl/mul_add_accum_result_mem.sv | 153 +++++++++++++++
 tb/tb_mul_add_accum_result_mem.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_add_accum_result_mem_if.sv
// Port bundle for the multiply-add result store:
// write, read and clear-control signals.
interface mul_add_accum_result_mem_if #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int ADDR_WIDTH    = 10
);
  localparam int RW = ELEMENT_WIDTH * NO_OF_UNITS;

  logic                   wr_en;
  logic                   wr_mode;
  logic [NO_OF_UNITS-1:0] wr_lane_mask;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [RW-1:0]          wr_data;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [RW-1:0]          rd_data;
  logic                   rd_valid;
  logic                   clr_start;
  logic                   busy;
  logic                   clr_done;

  modport master (
    output wr_en, wr_mode, wr_lane_mask,
    output wr_addr, wr_data,
    output rd_en, rd_addr, clr_start,
    input  rd_data, rd_valid, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_mode, wr_lane_mask,
    input  wr_addr, wr_data,
    input  rd_en, rd_addr, clr_start,
    output rd_data, rd_valid, busy, clr_done
  );
endinterface

// File: rtl/mul_add_accum_result_mem.sv
// Banked lane result store with masked/accumulating writes and a clear sequencer.
// Define MUL_ADD_RESULT_MEM_SAT_EN for signed saturating accumulate.
module mul_add_accum_result_mem #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int DEPTH         = 1024,
  parameter int ADDR_WIDTH    = 10
) (
  input logic clk,
  input logic rst,
  mul_add_accum_result_mem_if.slave bus
);
  localparam int EW = ELEMENT_WIDTH;
  localparam int NU = NO_OF_UNITS;
  localparam int RW = EW * NU;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  logic [RW-1:0] mem [DEPTH];

  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic busy, clr_done, clr_we;
  logic wr_acc, rd_acc;
  logic wr_in_range, rd_in_range;

  logic                  s1_valid;
  logic                  s1_mode;
  logic [NU-1:0]         s1_mask;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [RW-1:0]         s1_data;
  logic [RW-1:0]         s1_old;
  logic [RW-1:0]         commit_row;
  logic [RW-1:0]         fwd_row;
  logic [RW-1:0]         rd_data_q;
  logic                  rd_valid_q;

  function automatic logic [EW-1:0] lane_add(
    input logic [EW-1:0] a,
    input logic [EW-1:0] b
  );
    logic [EW-1:0] s;
    s = a + b;
`ifdef MUL_ADD_RESULT_MEM_SAT_EN
    if (a[EW-1] == b[EW-1] && s[EW-1] != a[EW-1])
      s = a[EW-1] ? {1'b1, {(EW-1){1'b0}}}
                  : {1'b0, {(EW-1){1'b1}}};
`endif
    return s;
  endfunction

  assign wr_in_range = 32'(bus.wr_addr) < DEPTH;
  assign rd_in_range = 32'(bus.rd_addr) < DEPTH;
  assign wr_acc = bus.wr_en && !busy && wr_in_range;
  assign rd_acc = bus.rd_en && !busy;

  always_comb begin
    commit_row = s1_old;
    for (int i = 0; i < NU; i++) begin
      if (s1_mask[i])
        commit_row[i*EW +: EW] = s1_mode
          ? lane_add(s1_old[i*EW +: EW], s1_data[i*EW +: EW])
          : s1_data[i*EW +: EW];
    end
  end

  // Old row comes from the in-flight commit when it targets the same row.
  always_comb begin
    fwd_row = '0;
    if (s1_valid && s1_addr == bus.wr_addr)
      fwd_row = commit_row;
    else if (wr_in_range)
      fwd_row = mem[bus.wr_addr[IW-1:0]];
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.clr_start)
          state_nx = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (!s1_valid) begin
          clr_we = 1'b1;
          if (clr_cnt == ADDR_WIDTH'(DEPTH - 1))
            state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        clr_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      s1_valid   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nx;
      s1_valid   <= wr_acc;
      rd_valid_q <= rd_acc;
      if (state == IDLE)
        clr_cnt <= '0;
      else if (clr_we)
        clr_cnt <= clr_cnt + 1'b1;
      if (rd_acc)
        rd_data_q <= rd_in_range
          ? mem[bus.rd_addr[IW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      s1_mode <= bus.wr_mode;
      s1_mask <= bus.wr_lane_mask;
      s1_addr <= bus.wr_addr;
      s1_data <= bus.wr_data;
      s1_old  <= fwd_row;
    end
  end

  // Array is deliberately left out of reset; rst only blocks commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (s1_valid)
        mem[s1_addr[IW-1:0]] <= commit_row;
      else if (clr_we)
        mem[clr_cnt[IW-1:0]] <= '0;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;
endmodule

// File: tb/tb_mul_add_accum_result_mem.sv
// Directed bench for mul_add_accum_result_mem
// (DEPTH=256, ADDR_WIDTH=9 so out-of-range rows are reachable).
module tb_mul_add_accum_result_mem;
  localparam int EW = 32;
  localparam int NU = 8;
  localparam int DEPTH = 256;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_add_accum_result_mem_if #(
    .ELEMENT_WIDTH(EW),
    .NO_OF_UNITS(NU),
    .ADDR_WIDTH(AW)
  ) mif ();

  mul_add_accum_result_mem #(
    .ELEMENT_WIDTH(EW),
    .NO_OF_UNITS(NU),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(mif)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic m,
                    input logic [7:0] mask, input logic [255:0] d);
    mif.wr_en = 1'b1;
    mif.wr_addr = a;
    mif.wr_mode = m;
    mif.wr_lane_mask = mask;
    mif.wr_data = d;
    step();
    mif.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag,
                    input logic [255:0] exp);
    mif.rd_en = 1'b1;
    mif.rd_addr = a;
    step();
    mif.rd_en = 1'b0;
    check({tag, "_valid"}, 256'(mif.rd_valid), 256'(1));
    check(tag, mif.rd_data, exp);
  endtask

  function automatic logic [255:0] rep(input logic [31:0] v);
    return {8{v}};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [255:0] exp_sat;
    int busy_cycles, done_cnt, rv_cnt, bad;

    mif.wr_en = 0; mif.wr_mode = 0; mif.wr_lane_mask = '0;
    mif.wr_addr = '0; mif.wr_data = '0;
    mif.rd_en = 0; mif.rd_addr = '0; mif.clr_start = 0;
    step(); step();
    check("rst_rd_valid", 256'(mif.rd_valid), 256'(0));
    check("rst_rd_data", mif.rd_data, 256'(0));
    check("rst_busy", 256'(mif.busy), 256'(0));
    check("rst_clr_done", 256'(mif.clr_done), 256'(0));
    rst = 1'b0;
    step();

    // 1: overwrite, read at T+2, valid lasts one cycle, data holds
    for (int i = 0; i < NU; i++) d[i*32 +: 32] = 32'(i + 1);
    wr(5, 0, 8'hFF, d);
    step();
    rd(5, "t1_row5", d);
    step();
    check("t1_valid_drop", 256'(mif.rd_valid), 256'(0));
    check("t1_data_hold", mif.rd_data, d);

    // 2: back-to-back accumulate to one row
    wr(3, 0, 8'hFF, rep(32'd10));
    for (int k = 0; k < 4; k++) wr(3, 1, 8'hFF, rep(32'd1));
    step();
    rd(3, "t2_acc_fwd", rep(32'd14));

    // 3: lane masks in both modes
    wr(7, 0, 8'hFF, rep(32'd0));
    wr(7, 0, 8'h0F, rep(32'd9));
    step();
    rd(7, "t3_mask_ow", {128'd0, {4{32'd9}}});
    wr(7, 1, 8'hF0, rep(32'd1));
    step();
    rd(7, "t3_mask_acc", {{4{32'd1}}, {4{32'd9}}});

    // 4: overflow at both signed extremes
    wr(2, 0, 8'hFF, rep(32'h7FFFFFFF));
    wr(2, 1, 8'hFF, rep(32'd1));
    step();
`ifdef MUL_ADD_RESULT_MEM_SAT_EN
    exp_sat = rep(32'h7FFFFFFF);
`else
    exp_sat = rep(32'h80000000);
`endif
    rd(2, "t4_pos_ovf", exp_sat);
    wr(4, 0, 8'hFF, rep(32'h80000000));
    wr(4, 1, 8'hFF, rep(32'hFFFFFFFF));
    step();
`ifdef MUL_ADD_RESULT_MEM_SAT_EN
    exp_sat = rep(32'h80000000);
`else
    exp_sat = rep(32'h7FFFFFFF);
`endif
    rd(4, "t4_neg_ovf", exp_sat);

    // out-of-range write must not alias onto row 0
    wr(0, 0, 8'hFF, rep(32'h11));
    wr(9'(DEPTH), 0, 8'hFF, rep(32'h5));
    step();
    rd(0, "oor_wr_dropped", rep(32'h11));
    rd(9'(DEPTH), "oor_rd_zero", 256'(0));

    // 5: fill all rows then clear with traffic during busy
    for (int r = 0; r < DEPTH; r++) wr(9'(r), 0, 8'hFF, rep(32'h100 + 32'(r)));
    mif.clr_start = 1'b1;
    step();
    busy_cycles = 0; done_cnt = 0; rv_cnt = 0;
    for (int k = 0; k < 400 && mif.busy; k++) begin
      busy_cycles++;
      if (mif.clr_done) done_cnt++;
      if (mif.rd_valid) rv_cnt++;
      mif.wr_en = 1; mif.wr_addr = 10; mif.wr_mode = 0;
      mif.wr_lane_mask = 8'hFF; mif.wr_data = '1;
      mif.rd_en = 1; mif.rd_addr = 10;
      step();
    end
    mif.wr_en = 0; mif.rd_en = 0; mif.clr_start = 0;
    check("t5_busy_ends", 256'(mif.busy), 256'(0));
    check("t5_busy_len_ok",
          256'(busy_cycles >= DEPTH + 1 && busy_cycles <= DEPTH + 3),
          256'(1));
    check("t5_done_pulses", 256'(done_cnt), 256'(1));
    check("t5_no_rd_valid", 256'(rv_cnt), 256'(0));
    step();
    bad = 0;
    for (int r = 0; r < DEPTH; r++) begin
      mif.rd_en = 1; mif.rd_addr = 9'(r);
      step();
      if (mif.rd_valid !== 1'b1 || mif.rd_data !== '0) bad++;
    end
    mif.rd_en = 0;
    check("t5_rows_zero", 256'(bad), 256'(0));

    // 6: reset in the middle of a clear
    wr(99, 0, 8'hFF, rep(32'h63));
    wr(200, 0, 8'hFF, rep(32'hC8));
    step();
    mif.clr_start = 1'b1;
    step();
    mif.clr_start = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy_off", 256'(mif.busy), 256'(0));
    rd(99, "t6_row99", 256'(0));
    rd(200, "t6_row200", rep(32'hC8));
    rd(9'(DEPTH), "t6_oor_rd", 256'(0));

    // same-cycle read misses a commit landing at that edge
    wr(6, 0, 8'hFF, rep(32'h66));
    mif.rd_en = 1; mif.rd_addr = 6;
    step();
    check("rw_t1_old", mif.rd_data, 256'(0));
    step();
    mif.rd_en = 0;
    check("rw_t2_new", mif.rd_data, rep(32'h66));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
